hdr_parser_engine: RTL and testbench

Parametrised, runtime-configurable header parser. It walks a packet held in word-addressed SRAM, starting at a given byte base address. Each header's offset is recorded by following a per-header next-tag table. Successor to the fixed two-header parser: it adds a parameter-sized header/table count, a config write port, a start/done handshake, byte-granular tag extraction (including tags that straddle two words), SRAM latency tolerance and loop-depth protection.

---
 rtl/hdr_parser_engine.sv | 224 ++++++++++++++++++++++
 tb/tb_hdr_parser_engine.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdr_parser_engine.sv
// Configurable header parser: walks a packet in word SRAM via per-header next-tag tables.
// Ports: cfg_* table writes, start/busy/done/err/hdr_cnt handshake, rd_hdr/rd_off query, sram_* read port.
module hdr_parser_engine #(
  parameter int NUM_HDRS  = 4,
  parameter int TBL_SIZE  = 4,
  parameter int SRAM_LAT  = 1,
  parameter int MAX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_sel,
  input  logic [15:0] cfg_hdr,
  input  logic [7:0]  cfg_idx,
  input  logic [31:0] cfg_data,
  input  logic        start,
  input  logic [31:0] pkt_base,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  hdr_cnt,
  input  logic [15:0] rd_hdr,
  output logic [31:0] rd_off,
  output logic        sram_ce_o,
  output logic        sram_we_o,
  output logic [31:0] sram_addr_o,
  output logic [3:0]  sram_sel_o,
  output logic [31:0] sram_data_o,
  input  logic [31:0] sram_data_i
);
  localparam int IW = (NUM_HDRS > 1) ? $clog2(NUM_HDRS) : 1;
  localparam int TW = (TBL_SIZE > 1) ? $clog2(TBL_SIZE) : 1;
  localparam int LW = $clog2(SRAM_LAT + 1);
  localparam logic [15:0] NH16 = 16'(NUM_HDRS);
  localparam logic [7:0]  TS8  = 8'(TBL_SIZE);
  localparam logic [7:0]  MD8  = 8'(MAX_DEPTH);
  localparam logic [15:0] NO_NXT = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE, S_RD0, S_WAIT0, S_RD1,
    S_WAIT1, S_MATCH, S_DONE
  } state_t;

  state_t state, state_n;

  logic [31:0] hdr_len   [NUM_HDRS];
  logic [31:0] tag_start [NUM_HDRS];
  logic [1:0]  tag_len   [NUM_HDRS];
  logic [15:0] tbl_tag   [NUM_HDRS][TBL_SIZE];
  logic [15:0] tbl_nxt   [NUM_HDRS][TBL_SIZE];
  logic [31:0] offs      [NUM_HDRS];

  logic [IW-1:0] cur_id;
  logic [31:0]   cur_addr;
  logic [7:0]    count;
  logic          err_q;
  logic [31:0]   w0;
  logic [7:0]    w1_b;
  logic [LW-1:0] lat_cnt;

  logic [31:0] t;
  logic [1:0]  cur_tl;
  logic        lat_done;
  logic        straddle;
  logic [7:0]  b0, b1;
  logic [15:0] tag;
  logic        hit;
  logic [15:0] win_nxt;
  logic [1:0]  win_tl;
  logic [7:0]  count_n;
  logic        stop;

  assign cur_tl   = tag_len[cur_id];
  assign t        = cur_addr + tag_start[cur_id];
  assign lat_done = (lat_cnt == LW'(SRAM_LAT - 1));
  assign straddle = (cur_tl == 2'd2) && (t[1:0] == 2'd3);
  assign count_n  = count + 8'd1;

  // byte t and t+1; t+1 spills into the second word when t is the last byte
  always_comb begin
    b0 = w0[7:0];
    b1 = w1_b;
    unique case (t[1:0])
      2'd0: begin b0 = w0[31:24]; b1 = w0[23:16]; end
      2'd1: begin b0 = w0[23:16]; b1 = w0[15:8];  end
      2'd2: begin b0 = w0[15:8];  b1 = w0[7:0];   end
      default: ;
    endcase
  end

  always_comb begin
    tag = 16'h0;
    if (cur_tl == 2'd1) tag = {8'h0, b0};
    else if (cur_tl == 2'd2) tag = {b0, b1};
  end

  // descending scan so the lowest matching index wins
  always_comb begin
    hit     = 1'b0;
    win_nxt = NO_NXT;
    for (int e = TBL_SIZE - 1; e >= 0; e--) begin
      if (cur_tl != 2'd0 &&
          tbl_nxt[cur_id][e] != NO_NXT &&
          tbl_tag[cur_id][e] == tag) begin
        hit     = 1'b1;
        win_nxt = tbl_nxt[cur_id][e];
      end
    end
  end

  assign stop   = (win_nxt >= NH16) || (count_n >= MD8);
  assign win_tl = (win_nxt < NH16) ?
                  tag_len[win_nxt[IW-1:0]] : 2'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (start)
          state_n = (tag_len[0] == 2'd0) ? S_MATCH : S_RD0;
      S_RD0: state_n = S_WAIT0;
      S_WAIT0:
        if (lat_done)
          state_n = straddle ? S_RD1 : S_MATCH;
      S_RD1: state_n = S_WAIT1;
      S_WAIT1:
        if (lat_done) state_n = S_MATCH;
      S_MATCH:
        if (!hit || stop)       state_n = S_DONE;
        else if (win_tl == 2'd0) state_n = S_MATCH;
        else                    state_n = S_RD0;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int h = 0; h < NUM_HDRS; h++) begin
        hdr_len[h]   <= '0;
        tag_start[h] <= '0;
        tag_len[h]   <= '0;
        offs[h]      <= 32'hFFFF_FFFF;
        for (int e = 0; e < TBL_SIZE; e++) begin
          tbl_tag[h][e] <= '0;
          tbl_nxt[h][e] <= NO_NXT;
        end
      end
      cur_id   <= '0;
      cur_addr <= '0;
      count    <= '0;
      err_q    <= 1'b0;
      w0       <= '0;
      w1_b     <= '0;
      lat_cnt  <= '0;
    end else begin
      if (cfg_we && !busy && cfg_hdr < NH16) begin
        unique case (cfg_sel)
          2'd0: hdr_len[cfg_hdr[IW-1:0]] <= cfg_data;
          2'd1: tag_start[cfg_hdr[IW-1:0]] <= cfg_data;
          2'd2: tag_len[cfg_hdr[IW-1:0]] <=
                  (cfg_data > 32'd2) ? 2'd2 : cfg_data[1:0];
          default:
            if (cfg_idx < TS8) begin
              tbl_tag[cfg_hdr[IW-1:0]][cfg_idx[TW-1:0]] <=
                cfg_data[31:16];
              tbl_nxt[cfg_hdr[IW-1:0]][cfg_idx[TW-1:0]] <=
                cfg_data[15:0];
            end
        endcase
      end
      unique case (state)
        S_IDLE:
          if (start) begin
            for (int h = 0; h < NUM_HDRS; h++)
              offs[h] <= 32'hFFFF_FFFF;
            cur_id   <= '0;
            cur_addr <= pkt_base;
            count    <= '0;
            err_q    <= 1'b0;
          end
        S_RD0, S_RD1: lat_cnt <= '0;
        S_WAIT0:
          if (lat_done) w0 <= sram_data_i;
          else lat_cnt <= lat_cnt + 1'b1;
        S_WAIT1:
          if (lat_done) w1_b <= sram_data_i[31:24];
          else lat_cnt <= lat_cnt + 1'b1;
        S_MATCH: begin
          offs[cur_id] <= cur_addr;
          count        <= count_n;
          cur_addr     <= cur_addr + hdr_len[cur_id];
          if (hit && stop) err_q <= 1'b1;
          if (hit && !stop) cur_id <= win_nxt[IW-1:0];
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state != S_IDLE) && (state != S_DONE);
  assign done    = (state == S_DONE);
  assign err     = err_q;
  assign hdr_cnt = count;
  assign rd_off  = (rd_hdr < NH16) ?
                   offs[rd_hdr[IW-1:0]] : 32'hFFFF_FFFF;

  assign sram_ce_o   = (state == S_RD0) || (state == S_RD1);
  assign sram_we_o   = 1'b0;
  assign sram_sel_o  = sram_ce_o ? 4'hF : 4'h0;
  assign sram_data_o = '0;
  always_comb begin
    sram_addr_o = '0;
    if (state == S_RD0)
      sram_addr_o = {2'b00, t[31:2]};
    else if (state == S_RD1)
      sram_addr_o = {2'b00, t[31:2]} + 32'd1;
  end
endmodule

// File: tb/tb_hdr_parser_engine.sv
// Scoreboard bench for hdr_parser_engine: two instances (SRAM latency 1 and 3) share stimulus.
// A procedural packet walker predicts reads, offsets, count and error; monitors compare.
module tb_hdr_parser_engine;
  localparam int NH = 4;
  localparam int TS = 4;
  localparam int MD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cfg_we   = 1'b0;
  logic [1:0]  cfg_sel  = '0;
  logic [15:0] cfg_hdr  = '0;
  logic [7:0]  cfg_idx  = '0;
  logic [31:0] cfg_data = '0;
  logic        start    = 1'b0;
  logic [31:0] pkt_base = '0;
  logic [15:0] rd_hdr   = '0;

  logic [1:0]  busy_w, done_w, err_w, ce_w, we_w;
  logic [7:0]  cnt_w  [2];
  logic [31:0] off_w  [2];
  logic [31:0] addr_w [2];
  logic [31:0] dout_w [2];
  logic [31:0] din_w  [2];
  logic [3:0]  sel_w  [2];

  hdr_parser_engine #(
    .NUM_HDRS(NH), .TBL_SIZE(TS),
    .SRAM_LAT(1), .MAX_DEPTH(MD)
  ) u_lat1 (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_hdr(cfg_hdr), .cfg_idx(cfg_idx),
    .cfg_data(cfg_data),
    .start(start), .pkt_base(pkt_base),
    .busy(busy_w[0]), .done(done_w[0]),
    .err(err_w[0]), .hdr_cnt(cnt_w[0]),
    .rd_hdr(rd_hdr), .rd_off(off_w[0]),
    .sram_ce_o(ce_w[0]), .sram_we_o(we_w[0]),
    .sram_addr_o(addr_w[0]), .sram_sel_o(sel_w[0]),
    .sram_data_o(dout_w[0]), .sram_data_i(din_w[0])
  );

  hdr_parser_engine #(
    .NUM_HDRS(NH), .TBL_SIZE(TS),
    .SRAM_LAT(3), .MAX_DEPTH(MD)
  ) u_lat3 (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_hdr(cfg_hdr), .cfg_idx(cfg_idx),
    .cfg_data(cfg_data),
    .start(start), .pkt_base(pkt_base),
    .busy(busy_w[1]), .done(done_w[1]),
    .err(err_w[1]), .hdr_cnt(cnt_w[1]),
    .rd_hdr(rd_hdr), .rd_off(off_w[1]),
    .sram_ce_o(ce_w[1]), .sram_we_o(we_w[1]),
    .sram_addr_o(addr_w[1]), .sram_sel_o(sel_w[1]),
    .sram_data_o(dout_w[1]), .sram_data_i(din_w[1])
  );

  // SRAM: data appears exactly LAT cycles after ce, junk otherwise
  logic [31:0] mem [64];
  logic [31:0] pd [2][3];
  logic [2:0]  pv [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv[0] <= '0;
      pv[1] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        pv[k]    <= {pv[k][1:0], ce_w[k]};
        pd[k][0] <= mem[addr_w[k][5:0]];
        pd[k][1] <= pd[k][0];
        pd[k][2] <= pd[k][1];
      end
    end
  end

  always_comb begin
    din_w[0] = pv[0][0] ? pd[0][0] : 32'hA5A5_A5A5;
    din_w[1] = pv[1][2] ? pd[1][2] : 32'hA5A5_A5A5;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm,
                          input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %h want nothing", nm, act);
  endtask

  // scoreboard queues, one pair per instance
  logic [31:0] aq [2][$];
  logic [8:0]  rq [2][$];
  int dn_cnt [2] = '{0, 0};

  always @(negedge clk) begin : mon
    logic [8:0] r;
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (ce_w[k]) begin
          chk($sformatf("sel%0d", k), 32'(sel_w[k]), 32'hF);
          chk($sformatf("wr%0d", k),
              dout_w[k] | 32'(we_w[k]), 32'h0);
          if (aq[k].size() == 0)
            fail_now($sformatf("rd_extra%0d", k), addr_w[k]);
          else
            chk($sformatf("rd_addr%0d", k),
                addr_w[k], aq[k].pop_front());
        end
        if (done_w[k]) begin
          dn_cnt[k]++;
          chk($sformatf("busy_at_done%0d", k),
              32'(busy_w[k]), 32'h0);
          if (rq[k].size() == 0)
            fail_now($sformatf("done_extra%0d", k), 32'(cnt_w[k]));
          else begin
            r = rq[k].pop_front();
            chk($sformatf("hdr_cnt%0d", k),
                32'(cnt_w[k]), 32'(r[7:0]));
            chk($sformatf("err%0d", k),
                32'(err_w[k]), 32'(r[8]));
          end
        end
      end
    end
  end

  // reference model state
  logic [31:0] m_len [NH];
  logic [31:0] m_ts  [NH];
  int          m_tl  [NH];
  logic [15:0] m_tag [NH][TS];
  logic [15:0] m_nid [NH][TS];
  logic [31:0] e_off [NH];

  task automatic model_reset();
    for (int h = 0; h < NH; h++) begin
      m_len[h] = 0; m_ts[h] = 0; m_tl[h] = 0;
      e_off[h] = 32'hFFFF_FFFF;
      for (int e = 0; e < TS; e++) begin
        m_tag[h][e] = 0;
        m_nid[h][e] = 16'hFFFF;
      end
    end
  endtask

  function automatic logic [7:0] mbyte(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[7:2]];
    case (a[1:0])
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  // walk the packet the way the header chain describes it
  task automatic model_run(input logic [31:0] base);
    logic [31:0] a, t, wa;
    logic [15:0] tag;
    int id, cnt, win, nid;
    logic e;
    for (int h = 0; h < NH; h++) e_off[h] = 32'hFFFF_FFFF;
    id = 0; a = base; cnt = 0; e = 1'b0;
    while (1) begin
      t = a + m_ts[id];
      tag = 0;
      if (m_tl[id] > 0) begin
        wa = t >> 2;
        for (int k = 0; k < 2; k++) aq[k].push_back(wa);
        if (m_tl[id] == 2 && t % 4 == 3)
          for (int k = 0; k < 2; k++) aq[k].push_back(wa + 1);
        if (m_tl[id] == 1) tag = {8'h0, mbyte(t)};
        else tag = {mbyte(t), mbyte(t + 1)};
      end
      e_off[id] = a;
      cnt++;
      a = a + m_len[id];
      win = -1;
      if (m_tl[id] > 0)
        for (int x = 0; x < TS; x++)
          if (win < 0 && m_nid[id][x] != 16'hFFFF &&
              m_tag[id][x] == tag)
            win = x;
      if (win < 0) break;
      nid = int'(m_nid[id][win]);
      if (nid >= NH || cnt == MD) begin
        e = 1'b1;
        break;
      end
      id = nid;
    end
    for (int k = 0; k < 2; k++) rq[k].push_back({e, 8'(cnt)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input logic [1:0] s, input int h,
                        input int i, input logic [31:0] d);
    logic take;
    take = (busy_w == 2'b00) && h < NH && (s != 2'd3 || i < TS);
    cfg_we = 1'b1; cfg_sel = s;
    cfg_hdr = 16'(h); cfg_idx = 8'(i); cfg_data = d;
    tick();
    cfg_we = 1'b0;
    if (take) begin
      case (s)
        2'd0: m_len[h] = d;
        2'd1: m_ts[h] = d;
        2'd2: m_tl[h] = (d > 2) ? 2 : int'(d);
        default: begin
          m_tag[h][i] = d[31:16];
          m_nid[h][i] = d[15:0];
        end
      endcase
    end
  endtask

  int d0, d1;

  task automatic launch(input logic [31:0] base);
    model_run(base);
    d0 = dn_cnt[0]; d1 = dn_cnt[1];
    pkt_base = base; start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy_w), 32'h3);
  endtask

  task automatic check_offs();
    for (int h = 0; h <= NH; h++) begin
      rd_hdr = 16'(h);
      #1;
      for (int k = 0; k < 2; k++)
        chk($sformatf("rd_off%0d_h%0d", k, h), off_w[k],
            (h < NH) ? e_off[h] : 32'hFFFF_FFFF);
    end
    rd_hdr = 16'hFFFF;
    #1;
    chk("rd_off_ffff", off_w[0] & off_w[1], 32'hFFFF_FFFF);
  endtask

  task automatic finish_pkt();
    int n;
    n = 0;
    while ((dn_cnt[0] == d0 || dn_cnt[1] == d1) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) fail_now("done_timeout", 32'(n));
    tick(); tick();
    chk("done_pulses0", 32'(dn_cnt[0] - d0), 32'd1);
    chk("done_pulses1", 32'(dn_cnt[1] - d1), 32'd1);
    check_offs();
    chk("reads_left", 32'(aq[0].size() + aq[1].size()), 0);
    chk("results_left", 32'(rq[0].size() + rq[1].size()), 0);
  endtask

  task automatic expect_off(input int h, input logic [31:0] v);
    rd_hdr = 16'(h);
    #1;
    chk($sformatf("direct_off_h%0d", h), off_w[0], v);
    chk($sformatf("direct_off3_h%0d", h), off_w[1], v);
  endtask

  task automatic expect_res(input int c, input logic e);
    chk("direct_cnt", 32'(cnt_w[0]), 32'(c));
    chk("direct_cnt3", 32'(cnt_w[1]), 32'(c));
    chk("direct_err", 32'(err_w), {30'h0, e, e});
  endtask

  task automatic eth_cfg();
    cfg_wr(0, 0, 0, 14); cfg_wr(1, 0, 0, 12); cfg_wr(2, 0, 0, 2);
    cfg_wr(3, 0, 0, {16'h0800, 16'h0001});
    for (int e = 1; e < TS; e++) cfg_wr(3, 0, e, 32'h0000_FFFF);
    cfg_wr(0, 1, 0, 20); cfg_wr(1, 1, 0, 9); cfg_wr(2, 1, 0, 1);
    for (int e = 0; e < TS; e++) cfg_wr(3, 1, e, 32'h0000_FFFF);
  endtask

  function automatic logic [15:0] rnid();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5) return 16'($urandom_range(0, NH - 1));
    if (r <= 7) return 16'(NH + $urandom_range(0, 1));
    return 16'hFFFF;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    for (int w = 0; w < 64; w++) mem[w] = 0;
    tick(); tick();
    chk("rst_busy", 32'(busy_w), 0);
    chk("rst_done", 32'(done_w), 0);
    chk("rst_err", 32'(err_w), 0);
    chk("rst_cnt", 32'(cnt_w[0]) | 32'(cnt_w[1]), 0);
    chk("rst_ce", 32'(ce_w), 0);
    chk("rst_addr", addr_w[0] | addr_w[1], 0);
    check_offs();
    rst = 1'b0;
    tick();

    // Eth -> IPv4
    eth_cfg();
    mem[3] = 32'h0800_1234;
    launch(0); finish_pkt();
    expect_off(0, 0); expect_off(1, 14); expect_res(2, 1'b0);

    // unknown ethertype
    mem[3] = 32'h86DD_0000;
    launch(0); finish_pkt();
    expect_off(1, 32'hFFFF_FFFF); expect_res(1, 1'b0);

    // tag straddling words 3/4
    mem[3] = 32'h1122_3308; mem[4] = 32'h0044_5566;
    launch(3); finish_pkt();
    expect_off(0, 3); expect_off(1, 17); expect_res(2, 1'b0);

    // start and config write while busy are ignored
    mem[3] = 32'h0800_0000;
    launch(0);
    tick();
    pkt_base = 3; start = 1'b1;
    tick();
    start = 1'b0;
    cfg_wr(0, 0, 0, 99);
    finish_pkt();
    launch(0); finish_pkt();
    expect_off(1, 14);

    // depth overflow on a self loop
    cfg_wr(0, 0, 0, 4);
    cfg_wr(3, 0, 0, {16'h0800, 16'h0000});
    for (int w = 3; w < 16; w++) mem[w] = 32'h0800_0800;
    launch(0); finish_pkt();
    expect_res(8, 1'b1); expect_off(0, 28);

    // reset during WAIT0
    eth_cfg();
    launch(0);
    tick();
    d0 = dn_cnt[0]; d1 = dn_cnt[1];
    rst = 1'b1;
    #1;
    chk("midrst_ce", 32'(ce_w), 0);
    chk("midrst_busy", 32'(busy_w), 0);
    model_reset();
    for (int k = 0; k < 2; k++) begin
      aq[k].delete();
      rq[k].delete();
    end
    check_offs();
    repeat (3) tick();
    rst = 1'b0;
    repeat (6) tick();
    chk("midrst_no_done", 32'(dn_cnt[0] - d0 + dn_cnt[1] - d1), 0);
    launch(8); finish_pkt();
    expect_off(0, 8); expect_res(1, 1'b0);

    // randomized configs and packets
    for (int it = 0; it < 40; it++) begin
      for (int h = 0; h < NH; h++) begin
        cfg_wr(0, h, 0, $urandom_range(0, 12));
        cfg_wr(1, h, 0, $urandom_range(0, 15));
        cfg_wr(2, h, 0, $urandom_range(0, 4));
        for (int e = 0; e < TS; e++)
          cfg_wr(3, h, e, {7'h0, 1'($urandom_range(0, 1)),
                           7'h0, 1'($urandom_range(0, 1)),
                           rnid()});
      end
      cfg_wr(0, NH + $urandom_range(0, 3), 0, 32'd7);
      cfg_wr(3, $urandom_range(0, NH - 1), TS + $urandom_range(0, 3),
             32'h0000_0000);
      for (int w = 0; w < 64; w++) mem[w] = $urandom() & 32'h0101_0101;
      launch($urandom_range(0, 40));
      finish_pkt();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
